// File: rtl/btb_pkg.sv
// Shared types and sizes for the IF-stage branch target buffer.
package btb_pkg;

  localparam int ADDR_W  = 32;
  localparam int ENTRIES = 32;
  localparam int IDX_W   = 5;
  localparam int TAG_W   = ADDR_W - IDX_W - 2;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] target;
  } btb_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } btb_state_e;

endpackage

// File: rtl/btb_entry_array.sv
// Direct-mapped BTB storage: async-reset valid bits, unreset tag/target.
module btb_entry_array
  import btb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output btb_entry_t        o_rd_entry,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [TAG_W-1:0]  i_wr_tag,
  input  logic [ADDR_W-1:0] i_wr_target,
  input  logic              i_clr,
  input  logic [IDX_W-1:0]  i_clr_idx
);

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag [ENTRIES];
  logic [ADDR_W-1:0]  r_tgt [ENTRIES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else begin
      if (i_clr) r_valid[i_clr_idx] <= 1'b0;
      if (i_we)  r_valid[i_wr_idx]  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[i_wr_idx] <= i_wr_tag;
      r_tgt[i_wr_idx] <= i_wr_target;
    end
  end

  assign o_rd_entry.valid  = r_valid[i_rd_idx];
  assign o_rd_entry.tag    = r_tag[i_rd_idx];
  assign o_rd_entry.target = r_tgt[i_rd_idx];

endmodule

// File: rtl/branch_target_buffer.sv
// IF-stage BTB: lookup, ID-side update, invalidate-all sweep, next_pc mux.
module branch_target_buffer
  import btb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              btb_hit,
  output logic [ADDR_W-1:0] btb_target,
  output logic [4:0]        branch_addr_lw_5b,
  input  logic              predict_br_taken,
  output logic [ADDR_W-1:0] next_pc,
  input  logic              upd_valid,
  input  logic              upd_stall,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_taken,
  input  logic              inv_req,
  output logic              inv_busy
);

  btb_state_e       r_state;
  btb_state_e       w_state_nxt;
  logic [IDX_W-1:0] r_cnt;
  logic [IDX_W-1:0] w_cnt_nxt;
  logic             w_clr;
  logic             w_we;
  btb_entry_t       w_rd;
  logic             w_unused;

  assign w_unused = ^{if_pc[1:0], upd_pc[1:0]};

  // Hit-and-taken rewrites and miss-and-taken allocates write the same
  // fields, so only the outcome decides whether a write happens.
  assign w_we = upd_valid & ~upd_stall & upd_taken
              & (r_state == IDLE) & ~inv_req;

  btb_entry_array u_arr (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rd_idx    (if_pc[IDX_W+1:2]),
    .o_rd_entry  (w_rd),
    .i_we        (w_we),
    .i_wr_idx    (upd_pc[IDX_W+1:2]),
    .i_wr_tag    (upd_pc[ADDR_W-1:IDX_W+2]),
    .i_wr_target (upd_target),
    .i_clr       (w_clr),
    .i_clr_idx   (r_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clr       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (inv_req) begin
          w_state_nxt = SWEEP;
          w_cnt_nxt   = '0;
        end
      end
      SWEEP: begin
        w_clr     = 1'b1;
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == IDX_W'(ENTRIES - 1)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign inv_busy = (r_state == SWEEP);

  assign btb_hit = if_valid & ~inv_busy & w_rd.valid
                 & (w_rd.tag == if_pc[ADDR_W-1:IDX_W+2]);

  assign btb_target        = btb_hit ? w_rd.target : '0;
  assign branch_addr_lw_5b = if_pc[6:2];
  assign next_pc = (btb_hit & predict_br_taken) ? btb_target
                                                : if_pc + 32'd4;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed plus random check of branch_target_buffer against a table model.
module tb_branch_target_buffer;

  logic        clk;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        btb_hit;
  logic [31:0] btb_target;
  logic [4:0]  branch_addr_lw_5b;
  logic        predict_br_taken;
  logic [31:0] next_pc;
  logic        upd_valid;
  logic        upd_stall;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        inv_req;
  logic        inv_busy;

  int total = 0;
  int bad   = 0;

  // Model: table keyed by slot (pc/4 mod 32), full pc stored per slot.
  bit          m_vld [32];
  logic [31:0] m_pc  [32];
  logic [31:0] m_tgt [32];
  int          m_busy_left;

  branch_target_buffer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .if_valid          (if_valid),
    .if_pc             (if_pc),
    .btb_hit           (btb_hit),
    .btb_target        (btb_target),
    .branch_addr_lw_5b (branch_addr_lw_5b),
    .predict_br_taken  (predict_br_taken),
    .next_pc           (next_pc),
    .upd_valid         (upd_valid),
    .upd_stall         (upd_stall),
    .upd_pc            (upd_pc),
    .upd_target        (upd_target),
    .upd_taken         (upd_taken),
    .inv_req           (inv_req),
    .inv_busy          (inv_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int slot(input logic [31:0] pc);
    return int'((pc / 4) % 32);
  endfunction

  function automatic bit m_hit();
    int s;
    s = slot(if_pc);
    return if_valid && m_busy_left == 0 && m_vld[s]
        && (m_pc[s] / 128) == (if_pc / 128);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_vld[i] = 1'b0;
    m_busy_left = 0;
  endtask

  task automatic m_clock();
    if (!rst_n) begin
      m_reset();
    end else if (m_busy_left > 0) begin
      m_vld[32 - m_busy_left] = 1'b0;
      m_busy_left--;
    end else if (inv_req) begin
      m_busy_left = 32;
    end else if (upd_valid && !upd_stall && upd_taken) begin
      m_vld[slot(upd_pc)] = 1'b1;
      m_pc[slot(upd_pc)]  = upd_pc;
      m_tgt[slot(upd_pc)] = upd_target;
    end
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    bit          h;
    logic [31:0] t;
    logic [31:0] n;
    h = m_hit();
    t = h ? m_tgt[slot(if_pc)] : 32'h0;
    n = (h && predict_br_taken) ? t : if_pc + 32'd4;
    cmp("hit",    {31'b0, btb_hit},  {31'b0, h});
    cmp("target", btb_target,        t);
    cmp("next",   next_pc,           n);
    cmp("busy",   {31'b0, inv_busy}, {31'b0, m_busy_left != 0});
    cmp("lw5b",   {27'b0, branch_addr_lw_5b}, (if_pc / 4) % 32);
  endtask

  task automatic cyc();
    @(negedge clk);
    chk_all();
    @(posedge clk);
    m_clock();
    #1;
  endtask

  task automatic lookup(input logic [31:0] pc);
    if_valid = 1'b1;
    if_pc    = pc;
    cyc();
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt,
                     input logic tk);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_target = tgt;
    upd_taken  = tk;
  endtask

  task automatic upd_off();
    upd_valid = 1'b0;
    upd_taken = 1'b0;
  endtask

  int busy_cnt;

  initial begin
    rst_n = 1'b0;
    if_valid = 1'b1; if_pc = 32'h40; predict_br_taken = 1'b1;
    upd_valid = 1'b0; upd_stall = 1'b0; upd_pc = '0;
    upd_target = '0; upd_taken = 1'b0; inv_req = 1'b0;
    m_reset();
    #2;
    cmp("rst_hit",  {31'b0, btb_hit}, 32'h0);
    cmp("rst_next", next_pc, 32'h44);
    cmp("rst_busy", {31'b0, inv_busy}, 32'h0);
    cmp("rst_tgt",  btb_target, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // allocate; same-cycle lookup sees old contents
    upd(32'h40, 32'h100, 1'b1);
    if_pc = 32'h40;
    @(negedge clk);
    cmp("nobypass", {31'b0, btb_hit}, 32'h0);
    @(posedge clk); m_clock(); #1;
    upd_off();
    @(negedge clk);
    cmp("alloc_hit",  {31'b0, btb_hit}, 32'h1);
    cmp("alloc_next", next_pc, 32'h100);
    cyc();

    // alias on slot 16
    upd(32'h1040, 32'h200, 1'b1);
    cyc();
    upd_off();
    lookup(32'h40);
    cmp("alias_old", {31'b0, btb_hit}, 32'h0);
    lookup(32'h1040);
    @(negedge clk);
    cmp("alias_new", btb_target, 32'h200);
    cyc();

    // not-taken: no allocation, hit entry untouched
    upd(32'h80, 32'h300, 1'b0);
    cyc();
    upd(32'h1040, 32'h300, 1'b0);
    cyc();
    upd_off();
    lookup(32'h80);
    lookup(32'h1040);
    @(negedge clk);
    cmp("nt_keep", btb_target, 32'h200);
    predict_br_taken = 1'b0;
    cyc();
    if_valid = 1'b0;
    cyc();
    predict_br_taken = 1'b1;

    // stall suppresses update
    upd_stall = 1'b1;
    upd(32'h84, 32'h500, 1'b1);
    cyc();
    upd_stall = 1'b0;
    upd_off();
    lookup(32'h84);

    // sweep with stray inv_req and dropped update
    for (int i = 0; i < 4; i++) begin
      upd(32'h10 + 32'(i * 4), 32'h800 + 32'(i), 1'b1);
      cyc();
    end
    upd(32'h20, 32'h900, 1'b1);
    inv_req = 1'b1;
    cyc();
    inv_req = 1'b0;
    upd_off();
    busy_cnt = 0;
    for (int k = 0; k < 34; k++) begin
      if_valid = 1'b1;
      if_pc = 32'h10 + 32'((k % 4) * 4);
      inv_req = (k == 10);
      if (k == 5) upd(32'h24, 32'hA00, 1'b1);
      else upd_off();
      @(negedge clk);
      if (inv_busy) busy_cnt++;
      chk_all();
      @(posedge clk); m_clock(); #1;
    end
    inv_req = 1'b0;
    cmp("sweep_len", busy_cnt, 32);
    for (int i = 0; i < 4; i++) lookup(32'h10 + 32'(i * 4));
    lookup(32'h20);
    lookup(32'h24);
    lookup(32'h1040);

    // async reset mid-sweep with an update pending
    upd(32'h30, 32'hB00, 1'b1);
    cyc();
    upd_off();
    lookup(32'h30);
    inv_req = 1'b1;
    cyc();
    inv_req = 1'b0;
    cyc(); cyc();
    upd(32'h34, 32'hC00, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("arst_busy", {31'b0, inv_busy}, 32'h0);
    cmp("arst_hit",  {31'b0, btb_hit}, 32'h0);
    @(posedge clk); m_clock(); #1;
    rst_n = 1'b1;
    upd_off();
    lookup(32'h34);
    lookup(32'h30);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      if_valid         = ($urandom_range(0, 7) != 0);
      if_pc            = ($urandom_range(0, 3) << 12)
                       | ($urandom_range(0, 31) << 2)
                       | $urandom_range(0, 3);
      predict_br_taken = $urandom_range(0, 1) == 1;
      upd_valid        = $urandom_range(0, 1) == 1;
      upd_stall        = ($urandom_range(0, 5) == 0);
      upd_pc           = ($urandom_range(0, 3) << 12)
                       | ($urandom_range(0, 31) << 2);
      upd_target       = $urandom;
      upd_taken        = ($urandom_range(0, 3) != 0);
      inv_req          = ($urandom_range(0, 60) == 0);
      if (n == 200) if_pc = 32'hFFFF_FFFC;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
